// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control FSM with memory-ready stalls; define MC_BNE_EN to add bne support.
module multicycle_ctrl #(
  parameter int OPW   = 6,
  parameter int CTRLW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   opcode,
  input  logic [OPW-1:0]   funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [CTRLW-1:0] alu_ctrl,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal_op,
  output logic [3:0]       state
);
  localparam logic [CTRLW-1:0] ALU_AND = CTRLW'(0);
  localparam logic [CTRLW-1:0] ALU_OR  = CTRLW'(1);
  localparam logic [CTRLW-1:0] ALU_ADD = CTRLW'(2);
  localparam logic [CTRLW-1:0] ALU_OFF = CTRLW'(3);
  localparam logic [CTRLW-1:0] ALU_SUB = CTRLW'(6);
  localparam logic [CTRLW-1:0] ALU_SLT = CTRLW'(7);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    R_EXEC    = 4'd2,
    R_WB      = 4'd3,
    MEM_ADDR  = 4'd4,
    MEM_RD    = 4'd5,
    MEM_WB    = 4'd6,
    MEM_WR    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    SLTI_EXEC = 4'd11,
`ifdef MC_BNE_EN
    IMM_WB    = 4'd12,
    BRANCH_NE = 4'd13
`else
    IMM_WB    = 4'd12
`endif
  } state_t;

  state_t state_q, state_d;
  logic [CTRLW-1:0] r_alu;
  logic r_ok;

  assign state = state_q;

  always_ff @(posedge clk)
    state_q <= !rst_n ? FETCH : state_d;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_OFF;
    case (funct)
      OPW'(6'b100000): r_alu = ALU_ADD;
      OPW'(6'b100010): r_alu = ALU_SUB;
      OPW'(6'b100100): r_alu = ALU_AND;
      OPW'(6'b100101): r_alu = ALU_OR;
      OPW'(6'b101010): r_alu = ALU_SLT;
      default:         r_ok  = 1'b0;
    endcase
  end

  // outputs are held at their idle values while reset is asserted
  always_comb begin
    state_d    = FETCH;
    alu_ctrl   = ALU_OFF;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_ctrl  = ALU_ADD;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
          state_d   = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          alu_ctrl  = ALU_ADD;
          case (opcode)
            OPW'(6'b000000): state_d = R_EXEC;
            OPW'(6'b100011),
            OPW'(6'b101011): state_d = MEM_ADDR;
            OPW'(6'b000100): state_d = BRANCH;
`ifdef MC_BNE_EN
            OPW'(6'b000101): state_d = BRANCH_NE;
`endif
            OPW'(6'b000010): state_d = JUMP;
            OPW'(6'b001000): state_d = ADDI_EXEC;
            OPW'(6'b001010): state_d = SLTI_EXEC;
            default:         illegal_op = 1'b1;
          endcase
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_ctrl  = r_alu;
          state_d   = R_WB;
        end
        R_WB: begin
          reg_dst   = 1'b1;
          reg_write = r_ok;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = ALU_ADD;
          state_d   = (opcode == OPW'(6'b100011)) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          state_d  = mem_ready ? MEM_WB : MEM_RD;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          state_d   = mem_ready ? FETCH : MEM_WR;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_ctrl  = ALU_SUB;
          pc_src    = 2'b01;
          pc_en     = zero;
        end
`ifdef MC_BNE_EN
        BRANCH_NE: begin
          alu_src_a = 1'b1;
          alu_ctrl  = ALU_SUB;
          pc_src    = 2'b01;
          pc_en     = ~zero;
        end
`endif
        JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        ADDI_EXEC, SLTI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = (state_q == SLTI_EXEC) ? ALU_SLT : ALU_ADD;
          state_d   = IMM_WB;
        end
        IMM_WB: reg_write = 1'b1;
        default: state_d = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle vectors queued as expectations and checked by a negedge monitor.
module tb_multicycle_ctrl;
  localparam logic [2:0] AND_ = 3'd0, OR_ = 3'd1, ADD_ = 3'd2, OFF_ = 3'd3, SUB_ = 3'd6, SLT_ = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic [2:0] alu_ctrl;
  logic alu_src_a, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] state;

  typedef struct {
    string      tag;
    logic [20:0] v;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // flags f = {pc_en,i_or_d,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,illegal_op}
  function automatic logic [20:0] mk(input logic [3:0] st, input logic [2:0] ac, input logic sa,
                                     input logic [1:0] sb, input logic [1:0] ps, input logic [8:0] f);
    return {st, ac, sa, sb, ps, f};
  endfunction

  task automatic cyc(input string tag, input logic rn, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [20:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rn; opcode = op; funct = fn; zero = z; mem_ready = mr;
    x.tag = tag; x.v = e;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t x;
      logic [20:0] act;
      x = q.pop_front();
      act = {state, alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, illegal_op};
      checks++;
      if (act !== x.v) begin
        errors++;
        $display("FAIL %s got %h expected %h", x.tag, act, x.v);
      end
    end
  end

  initial begin
    logic [20:0] rst0, fe, fe_st, de, de_ill;
    rst0   = mk(4'd0, OFF_, 0, 2'b00, 2'b00, 9'b000000000);
    fe     = mk(4'd0, ADD_, 0, 2'b01, 2'b00, 9'b101010000);
    fe_st  = mk(4'd0, ADD_, 0, 2'b01, 2'b00, 9'b001000000);
    de     = mk(4'd1, ADD_, 0, 2'b11, 2'b00, 9'b000000000);
    de_ill = mk(4'd1, ADD_, 0, 2'b11, 2'b00, 9'b000000001);

    cyc("reset1", 0, 6'h00, 6'h00, 0, 1, rst0);
    cyc("reset2", 0, 6'h00, 6'h00, 0, 1, rst0);

    // sub
    cyc("sub_fetch",  1, 6'b000000, 6'b100010, 0, 1, fe);
    cyc("sub_decode", 1, 6'b000000, 6'b100010, 0, 1, de);
    cyc("sub_exec",   1, 6'b000000, 6'b100010, 0, 1, mk(4'd2, SUB_, 1, 2'b00, 2'b00, 9'b000000000));
    cyc("sub_wb",     1, 6'b000000, 6'b100010, 0, 1, mk(4'd3, OFF_, 0, 2'b00, 2'b00, 9'b000001010));
    // unsupported funct
    cyc("badf_fetch",  1, 6'b000000, 6'b111111, 0, 1, fe);
    cyc("badf_decode", 1, 6'b000000, 6'b111111, 0, 1, de);
    cyc("badf_exec",   1, 6'b000000, 6'b111111, 0, 1, mk(4'd2, OFF_, 1, 2'b00, 2'b00, 9'b000000000));
    cyc("badf_wb",     1, 6'b000000, 6'b111111, 0, 1, mk(4'd3, OFF_, 0, 2'b00, 2'b00, 9'b000001000));
    // lw with two stall cycles in MEM_RD, plus one FETCH stall up front
    cyc("lw_fetch_stall", 1, 6'b100011, 6'h00, 0, 0, fe_st);
    cyc("lw_fetch",  1, 6'b100011, 6'h00, 0, 1, fe);
    cyc("lw_decode", 1, 6'b100011, 6'h00, 0, 1, de);
    cyc("lw_addr",   1, 6'b100011, 6'h00, 0, 1, mk(4'd4, ADD_, 1, 2'b10, 2'b00, 9'b000000000));
    cyc("lw_rd0",    1, 6'b100011, 6'h00, 0, 0, mk(4'd5, OFF_, 0, 2'b00, 2'b00, 9'b011000000));
    cyc("lw_rd1",    1, 6'b100011, 6'h00, 0, 0, mk(4'd5, OFF_, 0, 2'b00, 2'b00, 9'b011000000));
    cyc("lw_rd2",    1, 6'b100011, 6'h00, 0, 1, mk(4'd5, OFF_, 0, 2'b00, 2'b00, 9'b011000000));
    cyc("lw_wb",     1, 6'b100011, 6'h00, 0, 1, mk(4'd6, OFF_, 0, 2'b00, 2'b00, 9'b000000110));
    // sw
    cyc("sw_fetch",  1, 6'b101011, 6'h00, 0, 1, fe);
    cyc("sw_decode", 1, 6'b101011, 6'h00, 0, 1, de);
    cyc("sw_addr",   1, 6'b101011, 6'h00, 0, 1, mk(4'd4, ADD_, 1, 2'b10, 2'b00, 9'b000000000));
    cyc("sw_wr",     1, 6'b101011, 6'h00, 0, 1, mk(4'd7, OFF_, 0, 2'b00, 2'b00, 9'b010100000));
    // beq taken / not taken
    cyc("beq1_fetch",  1, 6'b000100, 6'h00, 1, 1, fe);
    cyc("beq1_decode", 1, 6'b000100, 6'h00, 1, 1, de);
    cyc("beq1_branch", 1, 6'b000100, 6'h00, 1, 1, mk(4'd8, SUB_, 1, 2'b00, 2'b01, 9'b100000000));
    cyc("beq0_fetch",  1, 6'b000100, 6'h00, 0, 1, fe);
    cyc("beq0_decode", 1, 6'b000100, 6'h00, 0, 1, de);
    cyc("beq0_branch", 1, 6'b000100, 6'h00, 0, 1, mk(4'd8, SUB_, 1, 2'b00, 2'b01, 9'b000000000));
    // illegal then jump
    cyc("ill_fetch",  1, 6'b111111, 6'h00, 0, 1, fe);
    cyc("ill_decode", 1, 6'b111111, 6'h00, 0, 1, de_ill);
    cyc("j_fetch",    1, 6'b000010, 6'h00, 0, 1, fe);
    cyc("j_decode",   1, 6'b000010, 6'h00, 0, 1, de);
    cyc("j_jump",     1, 6'b000010, 6'h00, 0, 1, mk(4'd9, OFF_, 0, 2'b00, 2'b10, 9'b100000000));
    // slti and addi
    cyc("slti_fetch",  1, 6'b001010, 6'h00, 0, 1, fe);
    cyc("slti_decode", 1, 6'b001010, 6'h00, 0, 1, de);
    cyc("slti_exec",   1, 6'b001010, 6'h00, 0, 1, mk(4'd11, SLT_, 1, 2'b10, 2'b00, 9'b000000000));
    cyc("slti_wb",     1, 6'b001010, 6'h00, 0, 1, mk(4'd12, OFF_, 0, 2'b00, 2'b00, 9'b000000010));
    cyc("addi_fetch",  1, 6'b001000, 6'h00, 0, 1, fe);
    cyc("addi_decode", 1, 6'b001000, 6'h00, 0, 1, de);
    cyc("addi_exec",   1, 6'b001000, 6'h00, 0, 1, mk(4'd10, ADD_, 1, 2'b10, 2'b00, 9'b000000000));
    cyc("addi_wb",     1, 6'b001000, 6'h00, 0, 1, mk(4'd12, OFF_, 0, 2'b00, 2'b00, 9'b000000010));
    // bne
    cyc("bne_fetch", 1, 6'b000101, 6'h00, 0, 1, fe);
`ifdef MC_BNE_EN
    cyc("bne_decode", 1, 6'b000101, 6'h00, 0, 1, de);
    cyc("bne_branch", 1, 6'b000101, 6'h00, 0, 1, mk(4'd13, SUB_, 1, 2'b00, 2'b01, 9'b100000000));
`else
    cyc("bne_illegal", 1, 6'b000101, 6'h00, 0, 1, de_ill);
`endif
    // reset asserted in the middle of a stalled store
    cyc("swr_fetch",  1, 6'b101011, 6'h00, 0, 1, fe);
    cyc("swr_decode", 1, 6'b101011, 6'h00, 0, 1, de);
    cyc("swr_addr",   1, 6'b101011, 6'h00, 0, 0, mk(4'd4, ADD_, 1, 2'b10, 2'b00, 9'b000000000));
    cyc("swr_wr_rst", 0, 6'b101011, 6'h00, 0, 0, mk(4'd7, OFF_, 0, 2'b00, 2'b00, 9'b000000000));
    cyc("swr_after",  0, 6'b101011, 6'h00, 0, 1, rst0);
    cyc("swr_fetch2", 1, 6'b101011, 6'h00, 0, 1, fe);
    cyc("swr_decode2", 1, 6'b101011, 6'h00, 0, 1, de);

    @(negedge clk);
    #1;
    if (q.size() != 0 || checks < 12) begin
      errors++;
      $display("FAIL drain got %0d pending %0d checks required 0 pending 12 checks", q.size(), checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
